// File: rtl/adc_decim_pkg.sv
// adc_decim_pkg: shared types, widths and helper functions for the ADC decimating averager
package adc_decim_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Lane accumulator width: enough headroom for 2^RATE_LOG2_MAX summed samples
    function automatic int acc_width(input int data_width, input int rate_log2_max);
        return data_width + rate_log2_max;
    endfunction

    // Width of the run-time decimation exponent
    function automatic int rate_width(input int rate_log2_max);
        return $clog2(rate_log2_max + 1);
    endfunction

    // LSB position of lane k in a packed lane bus
    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/adc_decim_lane.sv
// adc_decim_lane: per-channel boxcar accumulator, shift/round and result register (ADC_DECIM_ROUND_EN selects round-half-up)
module adc_decim_lane import adc_decim_pkg::*; #(
    parameter int DATA_WIDTH    = 14,
    parameter int RATE_LOG2_MAX = 4,
    parameter int RW            = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         accept,
    input  logic                         last,
    input  logic                         load,
    input  logic [RW-1:0]                rate,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int AW = acc_width(DATA_WIDTH, RATE_LOG2_MAX);

    logic signed [AW-1:0] acc, sum, biased;

    // Running sum including the current sample, optionally biased by half an LSB of the result
    always_comb begin
        sum = acc + AW'(sample);
`ifdef ADC_DECIM_ROUND_EN
        biased = (rate == '0) ? sum : sum + (AW'(1) << (rate - RW'(1)));
`else
        biased = sum;
`endif
    end

    // Accumulator restarts at a block boundary or when the block is abandoned
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clear || (accept && last))
            acc <= '0;
        else if (accept)
            acc <= sum;
    end

    // Result register holds the latest accepted average
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= '0;
        else if (load)
            result <= DATA_WIDTH'(biased >>> rate);
    end

endmodule

// File: rtl/adc_decim_avg.sv
// adc_decim_avg: multi-lane boxcar decimator with run-time ratio, one-entry output buffer and drop counting (ADC_DECIM_ROUND_EN enables rounding)
module adc_decim_avg import adc_decim_pkg::*; #(
    parameter int DATA_WIDTH    = 14,
    parameter int CHANNELS      = 2,
    parameter int RATE_LOG2_MAX = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [rate_width(RATE_LOG2_MAX)-1:0]  rate_log2,
    input  logic                                  in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        in_data,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0]        out_data,
    output logic                                  drop_pulse,
    output logic [DROP_CNT_W-1:0]                 drop_cnt
);

    localparam int RW = rate_width(RATE_LOG2_MAX);
    localparam int CW = RATE_LOG2_MAX + 1;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rate_q, rate_clamped, rate_eff;
    logic          accept, last, new_res, drop, load;

    // Enable tracking register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state plus block/handshake decode; the first sample of a block uses the live rate
    always_comb begin
        state_next   = en ? ACCUM : IDLE;
        rate_clamped = (rate_log2 > RW'(RATE_LOG2_MAX)) ? RW'(RATE_LOG2_MAX) : rate_log2;
        rate_eff     = (cnt == '0) ? rate_clamped : rate_q;
        accept       = (state == ACCUM) && en && in_valid;
        last         = cnt == (CW'(1) << rate_eff) - CW'(1);
        new_res      = accept && last;
        drop         = new_res && out_valid && !out_ready;
        load         = new_res && !drop;
    end

    // Sample counter and per-block rate latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rate_q <= '0;
        end else begin
            if (!en || new_res)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + CW'(1);
            if (accept && cnt == '0)
                rate_q <= rate_clamped;
        end
    end

    // One-entry output buffer and saturating drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            out_valid  <= load || (out_valid && !out_ready);
            drop_pulse <= drop;
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        adc_decim_lane #(
            .DATA_WIDTH   (DATA_WIDTH),
            .RATE_LOG2_MAX(RATE_LOG2_MAX),
            .RW           (RW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (!en),
            .accept(accept),
            .last  (last),
            .load  (load),
            .rate  (rate_eff),
            .sample(in_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .result(out_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_adc_decim_avg.sv
// tb_adc_decim_avg: scoreboard bench for adc_decim_avg with a block-averaging reference model
module tb_adc_decim_avg;

    localparam int DW = 14;
    localparam int CH = 2;
    localparam int RM = 4;
    localparam int RW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [RW-1:0]     rate_log2 = '0;
    logic              in_valid = 1'b0;
    logic [CH*DW-1:0]  in_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [CH*DW-1:0]  out_data;
    logic              drop_pulse;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    adc_decim_avg #(.DATA_WIDTH(DW), .CHANNELS(CH), .RATE_LOG2_MAX(RM)) dut (
        .clk(clk), .rst(rst), .en(en), .rate_log2(rate_log2), .in_valid(in_valid),
        .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit               m_state;
    int               s0[$], s1[$];
    int               m_rate;
    bit               m_full;
    bit               m_drop;
    int               m_dcnt;
    logic [CH*DW-1:0] exp_q[$];

    function automatic void chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    // Block average: sum divided by 2^r with floor (or round-half-up when enabled)
    function automatic int avg(input int s, input int r);
`ifdef ADC_DECIM_ROUND_EN
        if (r > 0) s += 1 << (r - 1);
`endif
        return s >>> r;
    endfunction

    function automatic void model_clear();
        s0.delete();
        s1.delete();
        exp_q.delete();
        m_state = 0; m_rate = 0; m_full = 0; m_drop = 0; m_dcnt = 0;
    endfunction

    // Apply the inputs seen at this clock edge to the model
    function automatic void model_edge();
        bit nres = 0;
        bit xfer = m_full && out_ready;
        logic [CH*DW-1:0] res = '0;
        if (m_state && en && in_valid) begin
            if (s0.size() == 0) m_rate = (int'(rate_log2) > RM) ? RM : int'(rate_log2);
            s0.push_back(int'($signed(in_data[0 +: DW])));
            s1.push_back(int'($signed(in_data[DW +: DW])));
            if (s0.size() == (1 << m_rate)) begin
                int a = 0, b = 0;
                foreach (s0[i]) begin a += s0[i]; b += s1[i]; end
                res = {DW'(avg(b, m_rate)), DW'(avg(a, m_rate))};
                nres = 1;
                s0.delete(); s1.delete();
            end
        end
        if (!en) begin s0.delete(); s1.delete(); end
        m_drop = nres && m_full && !out_ready;
        if (m_drop && m_dcnt < 65535) m_dcnt++;
        if (nres && !m_drop) begin
            exp_q.push_back(res);
            m_full = 1;
        end else if (xfer) m_full = 0;
        m_state = en;
    endfunction

    task automatic cyc(input bit e, input bit iv, input int a, input int b, input int rt, input bit rdy);
        en = e; in_valid = iv; in_data = {DW'(b), DW'(a)}; rate_log2 = RW'(rt); out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_drop_pulse", longint'(drop_pulse), 0);
        chk("rst_drop_cnt", longint'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every cycle and consumes expected results on transfer
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", longint'(out_valid), longint'(m_full));
            chk("drop_pulse", longint'(drop_pulse), longint'(m_drop));
            chk("drop_cnt", longint'(drop_cnt), longint'(m_dcnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_data: got %0h with no result expected at %0t", out_data, $time);
                end else begin
                    chk("out_data", longint'(out_data), longint'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();
        // Reset in the middle of a block
        cyc(1, 0, 0, 0, 2, 1);
        cyc(1, 1, 10, 10, 2, 1);
        cyc(1, 1, 10, 10, 2, 1);
        do_reset();
        cyc(1, 0, 0, 0, 2, 1);
        repeat (4) cyc(1, 1, 100, 100, 2, 1);
        repeat (3) cyc(1, 0, 0, 0, 2, 1);
        // Mixed-sign block with r=2
        cyc(1, 1, 1, -8, 2, 1);
        cyc(1, 1, 2, -8, 2, 1);
        cyc(1, 1, 3, -8, 2, 1);
        cyc(1, 1, 4, -7, 2, 1);
        repeat (2) cyc(1, 0, 0, 0, 2, 1);
        // r=0 pass-through ramp
        for (int i = 0; i < 10; i++) cyc(1, 1, i, -i, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 1);
        // r=1 with a stalled sink: one held, two dropped
        for (int i = 0; i < 6; i++) cyc(1, 1, 20 * i, -20 * i, 1, 0);
        repeat (3) cyc(1, 0, 0, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0, 1, 1);
        // Rate change mid-block, then clamping
        for (int i = 0; i < 2; i++) cyc(1, 1, 50 + i, -50 - i, 2, 1);
        for (int i = 0; i < 2; i++) cyc(1, 1, 60 + i, -60 - i, 4, 1);
        for (int i = 0; i < 16; i++) cyc(1, 1, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192, 4, 1);
        for (int i = 0; i < 16; i++) cyc(1, 1, 8191, -8192 + i, 7, 1);
        repeat (2) cyc(1, 0, 0, 0, 7, 1);
        // Partial block discarded by en low
        repeat (3) cyc(1, 1, 9, 9, 2, 1);
        cyc(0, 0, 0, 0, 2, 1);
        cyc(1, 0, 0, 0, 2, 1);
        repeat (4) cyc(1, 1, -5, -5, 2, 1);
        repeat (2) cyc(1, 0, 0, 0, 2, 1);
        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                $urandom_range(0, 7), $urandom_range(0, 2) != 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        chk("drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_decim_avg.md
Name: adc_decim_avg

Overview:
Parametrised successor to the pass-through downsampler between the ADC driver and the input FIFO. Boxcar-averages CHANNELS parallel signed ADC lanes over 2^rate_log2 samples, with the ratio selectable at run time. Emits one averaged word per block through a valid/ready handshake toward the FIFO write side. Drops blocks when the FIFO stalls and counts every drop.

Parameters:
DATA_WIDTH, 14, signed sample width per channel (input and output)
CHANNELS, 2, number of parallel lanes packed in the data buses
RATE_LOG2_MAX, 4, maximum decimation exponent (max ratio 16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  block enable; low discards any partial block
rate_log2  in  $clog2(RATE_LOG2_MAX+1)  decimation exponent; ratio = 2^rate_log2
in_valid  in  1  sample strobe for in_data
in_data  in  CHANNELS*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH], two's complement
out_ready  in  1  sink can accept (FIFO not almost_full and not in reset-busy)
out_valid  out  1  out_data holds an unconsumed result
out_data  out  CHANNELS*DATA_WIDTH  averaged lanes, same packing as in_data
drop_pulse  out  1  one-cycle pulse per dropped block
drop_cnt  out  16  saturating count of dropped blocks

Behaviour:
- Reset (async assert, clk-synchronous release): out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0, sample counter=0, all accumulators=0, state IDLE, latched rate=0.
- Accumulator width per lane: DATA_WIDTH+RATE_LOG2_MAX, signed; inputs sign-extended.
- States: IDLE (en=0) and ACCUM (en=1). IDLE->ACCUM when en=1. ACCUM->IDLE when en=0: the partial block is discarded and the counter and accumulators clear on that cycle. out_valid/out_data are not cleared by en.
- Rate latch: rate_log2 is captured only at a block start (counter=0 and in_valid in ACCUM). Changes mid-block take effect at the next block. Values >RATE_LOG2_MAX clamp to RATE_LOG2_MAX.
- Per accepted in_valid: acc += sample and counter++. A sample with counter = 2^r-1 is the last of its block.
- On the last sample: result = (acc+sample) >>> r (arithmetic shift, truncation toward -inf by default). Counter and accumulators restart at 0 on the same edge, so back-to-back blocks have no gap.
- Latency: out_valid rises on the cycle after the edge that registers the last sample. r=0 gives a registered pass-through with 1-cycle latency.
- Output buffer: one entry. A transfer occurs when out_valid && out_ready; out_valid drops the next cycle unless a new result loads simultaneously.
- Simultaneous consume and new result: the new result loads and out_valid stays 1.
- New result while out_valid=1 and out_ready=0: the new result is dropped and the old one is retained. drop_pulse=1 for one cycle and drop_cnt increments, saturating at 16'hFFFF.
- in_valid while en=0 is ignored.
- Averaging cannot overflow: |result| <= max |sample|.

Optional Feature:
ADC_DECIM_ROUND_EN
- Defined: add 2^(r-1) before the shift when r>0, giving round-half-up. The addition is performed in the accumulator width, so there is no overflow at full-scale positive.
- Undefined: plain truncating shift as above.
- r=0 is identical in both builds.

Decomposition:
- Package adc_decim_pkg holds:
  - function acc_width(DATA_WIDTH, RATE_LOG2_MAX)
  - rate-exponent width constant
  - localparam DROP_CNT_W=16
  - lane slice helper function
- Sub-module adc_decim_lane:
  - one per channel, via generate loop
  - contains the accumulator, shift/round logic and result register
  - shared counter, rate latch, handshake and drop logic stay in the top.

Test Plan:
- Reset mid-block: r=2, feed 2 samples, assert rst -> all outputs 0 immediately. After release, 4 samples of 100 -> out_data lanes = 100.
- r=2, out_ready=1, lane0 = 1,2,3,4 and lane1 = -8,-8,-8,-7 -> lane0 = 2, lane1 = -8 (truncating build); lane1 = -8 with ADC_DECIM_ROUND_EN (-31+2 = -29 >>> 2 = -8). out_valid high exactly one cycle after the 4th sample.
- r=0, continuous in_valid ramp 0..9 -> out_data replays 0..9 delayed by 1 cycle, out_valid continuously 1.
- r=1, out_ready=0, 6 samples -> first result held, next 2 results dropped, drop_pulse twice, drop_cnt=2. Then out_ready=1 -> held result transferred, out_valid=0.
- Change rate_log2 2->4 after the 2nd sample of a block -> current block still averages 4 samples, next block averages 16. Set rate_log2=7 -> clamps to 16-sample blocks.
- en low after 3 of 4 samples, then high and 4 new samples of -5 -> single output -5, with no contamination from the discarded partial block.
